// File: rtl/seq_driver.sv
// Vector-table sequencer for a sequence detector: clears the detector, plays a
// loaded table of {i1,i2,i3,i4} vectors with a programmable dwell, then checks its end state.
module seq_driver #(
    parameter int unsigned END_CODE   = 4100,
    parameter int unsigned CLR_CYCLES = 2,
    parameter int unsigned DEPTH      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        load_en,
    input  logic [3:0]  load_addr,
    input  logic [3:0]  load_data,
    input  logic [3:0]  num_steps,
    input  logic [7:0]  dwell,
    input  logic [16:0] det_state,
    output logic        det_reset,
    output logic        i1,
    output logic        i2,
    output logic        i3,
    output logic        i4,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  step_idx
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DRIVE,
        FINISH
    } state_t;

    localparam logic [3:0]  CLR_LOAD = 4'(CLR_CYCLES - 1);
    localparam logic [16:0] END_VAL  = 17'(END_CODE);

    state_t      state_q, state_n;
    logic [3:0]  clr_q, clr_n;
    logic [7:0]  dcnt_q, dcnt_n;
    logic [3:0]  steps_q, steps_n;
    logic [7:0]  dwell_q, dwell_n;
    logic [3:0]  step_q, step_n;
    logic [3:0]  vec_q, vec_n;
    logic        busy_q, busy_n;
    logic        done_q, done_n;
    logic        pass_q, pass_n;
    logic        drst_q, drst_n;
    logic [3:0]  tbl [DEPTH];

    // Table is only writable while idle, so a run always plays a stable table.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                tbl[k] <= '0;
            end
        end else if (load_en && (state_q == IDLE)) begin
            tbl[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            clr_q   <= '0;
            dcnt_q  <= '0;
            steps_q <= '0;
            dwell_q <= '0;
            step_q  <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            drst_q  <= 1'b1;
        end else begin
            state_q <= state_n;
            clr_q   <= clr_n;
            dcnt_q  <= dcnt_n;
            steps_q <= steps_n;
            dwell_q <= dwell_n;
            step_q  <= step_n;
            vec_q   <= vec_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            pass_q  <= pass_n;
            drst_q  <= drst_n;
        end
    end

    // Outputs are registered: each branch computes the values seen in the next state.
    always_comb begin
        state_n = state_q;
        clr_n   = clr_q;
        dcnt_n  = dcnt_q;
        steps_n = steps_q;
        dwell_n = dwell_q;
        step_n  = step_q;
        vec_n   = vec_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        pass_n  = pass_q;
        drst_n  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_n = CLEAR;
                    steps_n = num_steps;
                    dwell_n = (dwell == '0) ? 8'd1 : dwell;
                    clr_n   = CLR_LOAD;
                    step_n  = '0;
                    vec_n   = '0;
                    busy_n  = 1'b1;
                    pass_n  = 1'b0;
                    drst_n  = 1'b1;
                end
            end
            CLEAR: begin
                if (abort) begin
                    state_n = IDLE;
                    vec_n   = '0;
                    step_n  = '0;
                    busy_n  = 1'b0;
                    pass_n  = 1'b0;
                end else if (clr_q != '0) begin
                    clr_n  = clr_q - 4'd1;
                    drst_n = 1'b1;
                end else if (steps_q == '0) begin
                    state_n = FINISH;
                    done_n  = 1'b1;
                end else begin
                    state_n = DRIVE;
                    step_n  = '0;
                    vec_n   = tbl[0];
                    dcnt_n  = dwell_q - 8'd1;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_n = IDLE;
                    vec_n   = '0;
                    step_n  = '0;
                    busy_n  = 1'b0;
                    pass_n  = 1'b0;
                end else if (dcnt_q != '0) begin
                    dcnt_n = dcnt_q - 8'd1;
                end else if (step_q == steps_q - 4'd1) begin
                    state_n = FINISH;
                    done_n  = 1'b1;
                end else begin
                    step_n = step_q + 4'd1;
                    vec_n  = tbl[step_q + 4'd1];
                    dcnt_n = dwell_q - 8'd1;
                end
            end
            FINISH: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                pass_n  = (det_state == END_VAL);
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign det_reset        = drst_q;
    assign {i1, i2, i3, i4} = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign step_idx         = step_q;

endmodule

// File: doc/seq_driver.md
SEQ_DRIVER -- requirements
Module: seq_driver

Interface
REQ-001 The block SHALL provide parameter END_CODE, default 4100, meaning the detector state code that signals a completed sequence.
REQ-002 The block SHALL provide parameter CLR_CYCLES, default 2, meaning the number of cycles det_reset is held at run start (legal range 1-15).
REQ-003 The block SHALL provide parameter DEPTH, default 16, meaning the number of vector table entries (table holds fixed 16 entries; DEPTH is fixed at 16).
REQ-004 clk  input  1  system clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle run request.
REQ-007 abort  input  1  terminate the current run.
REQ-008 load_en  input  1  write load_data into table entry load_addr.
REQ-009 load_addr  input  4  table write address.
REQ-010 load_data  input  4  vector {i1,i2,i3,i4}, bit 3 = i1.
REQ-011 num_steps  input  4  number of table entries to play, sampled at start.
REQ-012 dwell  input  8  cycles each vector is held, sampled at start.
REQ-013 det_state  input  17  state code reported by the sequence detector.
REQ-014 det_reset  output  1  synchronous reset to the detector.
REQ-015 i1, i2, i3, i4  output  1 each  registered detector input drives.
REQ-016 busy  output  1  high while a run is in progress.
REQ-017 done  output  1  one-cycle pulse at normal run completion.
REQ-018 pass  output  1  result of the last completed run.
REQ-019 step_idx  output  4  index of the table entry currently driven.

Function
REQ-020 The controller SHALL implement states IDLE, CLEAR, DRIVE, FINISH.
REQ-021 In IDLE, start=1 SHALL sample num_steps and dwell, set busy, clear pass, and enter CLEAR on the next edge.
REQ-022 CLEAR SHALL assert det_reset for exactly CLR_CYCLES cycles with i1-i4 = 0, then enter DRIVE with step_idx = 0; if the sampled num_steps = 0, it SHALL enter FINISH instead.
REQ-023 DRIVE SHALL present table[step_idx] on {i1,i2,i3,i4} for max(dwell,1) cycles; dwell = 0 SHALL be treated as 1.
REQ-024 After the last cycle of entry num_steps-1, DRIVE SHALL enter FINISH; otherwise it SHALL increment step_idx and reload the dwell counter with no gap cycle.
REQ-025 FINISH SHALL last one cycle: done = 1, pass <= (det_state == END_CODE), busy = 0 thereafter, i1-i4 held at the last vector, then return to IDLE.
REQ-026 Run length from the cycle after start SHALL be CLR_CYCLES + N*max(dwell,1) + 1 cycles for sampled num_steps N.
REQ-027 pass SHALL hold its value until the next accepted start or reset.
REQ-028 start while busy SHALL be ignored.
REQ-029 load_en SHALL write only in IDLE; writes while busy SHALL be dropped, and table contents SHALL be unaffected by runs.
REQ-030 abort in CLEAR or DRIVE SHALL return to IDLE on the next edge with i1-i4 = 0, busy = 0, done = 0, pass = 0, and step_idx = 0.
REQ-031 abort and start in the same IDLE cycle: abort SHALL win and no run SHALL start.
REQ-032 num_steps and dwell changes during a run SHALL have no effect.
REQ-033 det_state SHALL be sampled only in FINISH.

Reset
REQ-034 reset SHALL asynchronously force IDLE, i1-i4 = 0, busy = 0, done = 0, pass = 0, step_idx = 0, and det_reset = 1 while reset is high.
REQ-035 det_reset SHALL deassert on the first clk edge after reset is released.
REQ-036 Table contents SHALL be cleared to 0 by reset.
REQ-037 reset mid-run SHALL abandon the run with no done pulse.

Verification
REQ-038 Load the entries 0x2, 0x9, 0x9, 0x0, 0x2, 0x4, then start with num_steps = 6 and dwell = 3, while the detector model reports END_CODE at FINISH -> busy for 2 + 18 + 1 cycles, then done pulses once and pass = 1.
REQ-039 Same run with det_state = 200 at FINISH -> done = 1 and pass = 0.
REQ-040 Start with num_steps = 0 -> det_reset for 2 cycles, then FINISH on the 3rd cycle, with i1-i4 never nonzero.
REQ-041 Start with dwell = 0 and num_steps = 4 -> each vector is held for exactly 1 cycle, and step_idx steps 0 through 3 on consecutive cycles.
REQ-042 Abort on the 2nd DRIVE cycle, and a second start while busy -> second start ignored, return to IDLE, no done pulse, and i1-i4 = 0.
REQ-043 Assert reset asynchronously mid-DRIVE, then attempt load_en during a run -> outputs clear without a clock edge, det_reset = 1, and the table entry is unchanged.
